// File: rtl/pipe_bimpy_mpy.sv
// ---------------------------------------------------------------------------
// pipe_bimpy_mpy
//   Fully pipelined IAW x IBW multiplier. Operand A is consumed two bits per
//   stage. Each stage forms a small 2 x IBW partial product and adds it into a
//   registered accumulator. One operand pair is accepted per enabled clock.
//   Signed mode multiplies the magnitudes and applies the sign at the output.
//   A valid tag travels alongside the data. Latency is ceil(IAW/2)+2 enabled
//   clock edges.
//
// Ports
//   i_clk      rising-edge clock
//   i_reset_n  asynchronous active-low reset; clears every pipeline register
//   i_ce       clock enable; the whole pipeline holds when low
//   i_valid    operands on i_a / i_b are valid
//   i_a        operand A (IAW bits, scanned two bits per stage)
//   i_b        operand B (IBW bits)
//   o_valid    o_p holds a finished product
//   o_p        product, IAW+IBW bits (two's complement when OPT_SIGNED=1)
// ---------------------------------------------------------------------------
module pipe_bimpy_mpy #(
  parameter int IAW        = 16,
  parameter int IBW        = 16,
  parameter int OPT_SIGNED = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_ce,
  input  logic                 i_valid,
  input  logic [IAW-1:0]       i_a,
  input  logic [IBW-1:0]       i_b,
  output logic                 o_valid,
  output logic [IAW+IBW-1:0]   o_p
);

  localparam int K   = (IAW + 1) / 2;
  localparam int AW2 = 2 * K;
  localparam int OW  = IAW + IBW;

  localparam logic [IAW-1:0] ONE_A = {{(IAW-1){1'b0}}, 1'b1};
  localparam logic [IBW-1:0] ONE_B = {{(IBW-1){1'b0}}, 1'b1};
  localparam logic [OW-1:0]  ONE_P = {{(OW-1){1'b0}}, 1'b1};

  // Inter-stage buses. Index k is the output of stage k (stage 0 = input).
  // A bits and B are not needed after the last multiply stage.
  logic [OW-1:0]  acc_w [0:K];
  logic           v_w   [0:K];
  logic           neg_w [0:K];
  logic [AW2-1:0] ma_w  [0:K-1];
  logic [IBW-1:0] mb_w  [0:K-1];

  // ------------------------------------------------------------------
  // Stage 0: capture operands as magnitudes plus a result sign.
  // ------------------------------------------------------------------
  logic           v0_d, v0_q;
  logic           neg0_d, neg0_q;
  logic [AW2-1:0] ma0_d, ma0_q;
  logic [IBW-1:0] mb0_d, mb0_q;
  logic [IAW-1:0] a_mag;
  logic [IBW-1:0] b_mag;

  always_comb begin
    a_mag  = i_a;
    b_mag  = i_b;
    neg0_d = 1'b0;
    if (OPT_SIGNED != 0) begin
      // The most negative value negates to itself, which read as unsigned
      // is exactly its magnitude, so no extra bit is needed.
      if (i_a[IAW-1]) a_mag = ~i_a + ONE_A;
      if (i_b[IBW-1]) b_mag = ~i_b + ONE_B;
      neg0_d = i_a[IAW-1] ^ i_b[IBW-1];
    end
    v0_d  = i_valid;
    ma0_d = AW2'(a_mag);
    mb0_d = b_mag;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v0_q   <= 1'b0;
      neg0_q <= 1'b0;
      ma0_q  <= '0;
      mb0_q  <= '0;
    end else if (i_ce) begin
      v0_q   <= v0_d;
      neg0_q <= neg0_d;
      ma0_q  <= ma0_d;
      mb0_q  <= mb0_d;
    end
  end

  assign acc_w[0] = '0;
  assign v_w[0]   = v0_q;
  assign neg_w[0] = neg0_q;
  assign ma_w[0]  = ma0_q;
  assign mb_w[0]  = mb0_q;

  // ------------------------------------------------------------------
  // Stages 1..K: each consumes the two lowest remaining A bits.
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 1; gi <= K; gi++) begin : g_stage
      localparam int SH = 2 * gi - 2;

      logic [1:0]     a_slice;
      logic [IBW+1:0] pp0, pp1, pp;
      logic [OW-1:0]  acc_d, acc_q;
      logic           v_d, v_q;
      logic           neg_d, neg_q;

      always_comb begin
        a_slice = ma_w[gi-1][1:0];
        pp0     = a_slice[0] ? {2'b00, mb_w[gi-1]}       : '0;
        pp1     = a_slice[1] ? {1'b0, mb_w[gi-1], 1'b0}  : '0;
        // Half-adder form of pp0+pp1; the result is at most 3*mb and
        // always fits in IBW+2 bits.
        pp      = (pp0 ^ pp1) + ((pp0 & pp1) << 1);
        // The running sum is bounded by the final product, so it never
        // exceeds OW bits even when the top slice is padded for odd IAW.
        acc_d   = acc_w[gi-1] + (OW'(pp) << SH);
        v_d     = v_w[gi-1];
        neg_d   = neg_w[gi-1];
      end

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          acc_q <= '0;
          v_q   <= 1'b0;
          neg_q <= 1'b0;
        end else if (i_ce) begin
          acc_q <= acc_d;
          v_q   <= v_d;
          neg_q <= neg_d;
        end
      end

      assign acc_w[gi] = acc_q;
      assign v_w[gi]   = v_q;
      assign neg_w[gi] = neg_q;

      if (gi < K) begin : g_fwd
        logic [AW2-1:0] ma_d, ma_q;
        logic [IBW-1:0] mb_d, mb_q;

        always_comb begin
          ma_d = ma_w[gi-1] >> 2;
          mb_d = mb_w[gi-1];
        end

        always_ff @(posedge i_clk or negedge i_reset_n) begin
          if (!i_reset_n) begin
            ma_q <= '0;
            mb_q <= '0;
          end else if (i_ce) begin
            ma_q <= ma_d;
            mb_q <= mb_d;
          end
        end

        assign ma_w[gi] = ma_q;
        assign mb_w[gi] = mb_q;
      end
    end
  endgenerate

  // ------------------------------------------------------------------
  // Output stage: restore the sign. Negating zero gives zero.
  // ------------------------------------------------------------------
  logic          o_valid_d, o_valid_q;
  logic [OW-1:0] o_p_d, o_p_q;

  always_comb begin
    o_valid_d = v_w[K];
    o_p_d     = acc_w[K];
    if (neg_w[K]) o_p_d = ~acc_w[K] + ONE_P;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid_q <= 1'b0;
      o_p_q     <= '0;
    end else if (i_ce) begin
      o_valid_q <= o_valid_d;
      o_p_q     <= o_p_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_p     = o_p_q;

endmodule

// File: tb/tb_pipe_bimpy_mpy.sv
// ---------------------------------------------------------------------------
// tb_pipe_bimpy_mpy
//   Three multiplier instances share clock, reset and clock enable:
//     cfg0: 8x8 signed, cfg1: 8x8 unsigned, cfg2: 7x5 signed.
//   Each instance has a reference model: a queue of (valid, A*B) entries
//   pushed on every enabled edge. The output seen after an edge is the
//   entry pushed LAT enabled edges earlier (the sampling edge counts as one).
//   Directed scenarios run first, then randomized traffic with random
//   clock-enable gaps.
// ---------------------------------------------------------------------------
module tb_pipe_bimpy_mpy;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        ce    = 1'b1;
  logic [31:0] a_drv [3];
  logic [31:0] b_drv [3];
  logic        v_drv [3];
  bit          verbose = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cfg
      localparam int IAW_C = (gi == 2) ? 7 : 8;
      localparam int IBW_C = (gi == 2) ? 5 : 8;
      localparam int SGN_C = (gi == 1) ? 0 : 1;
      localparam int OW_C  = IAW_C + IBW_C;
      localparam int LAT_C = (IAW_C + 1) / 2 + 2;

      logic            o_valid;
      logic [OW_C-1:0] o_p;
      bit              vq [$];
      logic [OW_C-1:0] pq [$];
      logic            exp_v = 1'b0;
      logic [OW_C-1:0] exp_p = '0;

      pipe_bimpy_mpy #(
        .IAW(IAW_C), .IBW(IBW_C), .OPT_SIGNED(SGN_C)
      ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_ce     (ce),
        .i_valid  (v_drv[gi]),
        .i_a      (a_drv[gi][IAW_C-1:0]),
        .i_b      (b_drv[gi][IBW_C-1:0]),
        .o_valid  (o_valid),
        .o_p      (o_p)
      );

      function automatic logic [OW_C-1:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        logic [IAW_C-1:0] as;
        logic [IBW_C-1:0] bs;
        longint av, bv;
        as = a[IAW_C-1:0];
        bs = b[IBW_C-1:0];
        if (SGN_C != 0) begin
          av = longint'($signed(as));
          bv = longint'($signed(bs));
        end else begin
          av = longint'(as);
          bv = longint'(bs);
        end
        return OW_C'(av * bv);
      endfunction

      always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vq.delete();
          pq.delete();
          exp_v = 1'b0;
          exp_p = '0;
        end else if (ce) begin
          vq.push_back(v_drv[gi]);
          pq.push_back(ref_prod(a_drv[gi], b_drv[gi]));
          if (vq.size() > LAT_C) begin
            void'(vq.pop_front());
            void'(pq.pop_front());
          end
          if (vq.size() == LAT_C) begin
            exp_v = vq[0];
            exp_p = pq[0];
          end else begin
            exp_v = 1'b0;
          end
        end
      end

      always @(negedge clk) begin
        check($sformatf("cfg%0d_valid", gi), 64'(o_valid), 64'(exp_v));
        if (exp_v) begin
          check($sformatf("cfg%0d_product", gi), 64'(o_p), 64'(exp_p));
          if (verbose)
            $display("cfg%0d result: o_p=0x%0h expected=0x%0h", gi, o_p, exp_p);
        end
        if (!rst_n)
          check($sformatf("cfg%0d_reset_p", gi), 64'(o_p), 64'(0));
      end
    end
  endgenerate

  task automatic drive(input int j, input logic v, input logic [31:0] a, input logic [31:0] b);
    v_drv[j] = v;
    a_drv[j] = a;
    b_drv[j] = b;
  endtask

  task automatic idle();
    for (int j = 0; j < 3; j++) v_drv[j] = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] corner(input int w, input int k);
    logic [31:0] one;
    one = 32'd1;
    case (k)
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return one << (w - 1);
      default: return (one << (w - 1)) - one;
    endcase
  endfunction

  function automatic logic [31:0] pick(input int w);
    if ($urandom_range(0, 3) == 0) return corner(w, int'($urandom_range(0, 3)));
    return $urandom;
  endfunction

  initial begin
    for (int j = 0; j < 3; j++) drive(j, 1'b0, 32'd0, 32'd0);
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Single signed extreme product: -128 * -128
    drive(0, 1'b1, -32'sd128, -32'sd128);
    tick();
    idle();
    repeat (8) tick();

    // Back-to-back signed pairs
    drive(0, 1'b1, 32'sd127, -32'sd128); tick();
    drive(0, 1'b1, -32'sd1,  -32'sd1);   tick();
    drive(0, 1'b1, 32'sd0,   -32'sd77);  tick();
    drive(0, 1'b1, -32'sd5,  32'sd3);    tick();
    idle();
    repeat (8) tick();

    // Unsigned full scale and small operands
    drive(1, 1'b1, 32'd255, 32'd255); tick();
    drive(1, 1'b1, 32'd1,   32'd200); tick();
    idle();
    repeat (8) tick();

    // Odd IAW, signed extremes
    drive(2, 1'b1, -32'sd64, -32'sd16); tick();
    drive(2, 1'b1, 32'sd63,  32'sd15);  tick();
    idle();
    repeat (8) tick();

    // Clock-enable stall after two enabled edges
    drive(0, 1'b1, 32'sd12, -32'sd3);
    tick();
    idle();
    tick();
    ce = 1'b0;
    repeat (3) tick();
    ce = 1'b1;
    repeat (8) tick();

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) drive(j, 1'b1, $urandom, $urandom);
      tick();
    end
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("cfg0_async_valid", 64'(g_cfg[0].o_valid), 64'(0));
    check("cfg0_async_p",     64'(g_cfg[0].o_p),     64'(0));
    check("cfg1_async_valid", 64'(g_cfg[1].o_valid), 64'(0));
    check("cfg2_async_valid", 64'(g_cfg[2].o_valid), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    drive(0, 1'b1, -32'sd100, 32'sd99);
    drive(1, 1'b1, 32'd17,    32'd240);
    drive(2, 1'b1, -32'sd3,   -32'sd7);
    tick();
    idle();
    repeat (8) tick();

    // Randomized traffic with clock-enable gaps
    verbose = 1'b0;
    for (int i = 0; i < 600; i++) begin
      ce = ($urandom_range(0, 7) != 0);
      for (int j = 0; j < 3; j++) begin
        v_drv[j] = ($urandom_range(0, 3) != 0);
        a_drv[j] = pick((j == 2) ? 7 : 8);
        b_drv[j] = pick((j == 2) ? 5 : 8);
      end
      tick();
    end
    ce = 1'b1;
    idle();
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_bimpy_mpy.md
Name: pipe_bimpy_mpy

Overview:
Fully pipelined IAW x IBW multiplier. It retires two bits of operand A per stage, using a registered 2xN partial-product adder per stage, and accepts one new operand pair per enabled clock. Optional signed mode applies sign-magnitude pre- and post-conditioning. Valid tags travel with the data. The block sits in the FFT butterfly and twiddle datapath as the generic wide product engine, built from 2-bit multiply steps.

Parameters:
IAW, 16, width of operand A (multiplier, scanned 2 bits per stage); legal range 2..32.
IBW, 16, width of operand B (multiplicand); legal range 2..32.
OPT_SIGNED, 1, 1 = two's-complement operands and product; 0 = unsigned.
Derived constants, not overridable:
- K = ceil(IAW/2)
- AW2 = 2*K (A zero-extended to an even width)
- OW = IAW+IBW
- LAT = K+2

Ports:
i_clk  input  1  rising-edge clock
i_reset_n  input  1  asynchronous active-low reset
i_ce  input  1  clock enable; the pipeline advances only when high
i_valid  input  1  operands on i_a/i_b are valid (sampled when i_ce=1)
i_a  input  IAW  operand A
i_b  input  IBW  operand B
o_valid  output  1  o_p holds a finished product
o_p  output  OW  product A*B (signed if OPT_SIGNED)

Behaviour:
- Reset: while i_reset_n=0, asynchronously clear every pipeline register.
  - o_valid=0 and o_p=0.
  - All stage valid bits and accumulators are 0.
  - Release is synchronous to the next i_clk edge. In-flight operations are discarded, not completed.
- i_ce=0: every register, including o_valid and o_p, holds its value. No bubble is inserted and no data is lost.
- Stage 0 (input/abs), on i_ce:
  - Register v0=i_valid.
  - If OPT_SIGNED: ma=|i_a| (IAW unsigned bits, so -2^(IAW-1) maps to 2^(IAW-1) with no overflow), mb=|i_b| (IBW bits), neg=i_a[MSB]^i_b[MSB].
  - Else: ma=i_a, mb=i_b, neg=0.
  - ma is zero-extended to AW2 bits.
- Stages k=1..K, on i_ce:
  - acc_k = acc_(k-1) + (ma[2k-1:2k-2] * mb) << (2k-2), with acc_0=0.
  - The 2xIBW partial product is formed combinationally as the XOR sum plus AND carry of the two shifted/gated copies of mb, then added to the accumulator in one registered adder.
  - Each stage forwards the unconsumed A bits, mb, neg and valid.
  - acc width is OW bits; intermediates never overflow OW.
- Stage K+1 (output), on i_ce:
  - o_p = neg ? (~acc_K + 1) : acc_K, truncated to OW bits.
  - o_valid = v_K.
- Latency: a pair sampled with i_valid=1 on enabled edge n appears with o_valid=1 after exactly LAT enabled edges. Disabled cycles do not count.
- Throughput: one result per enabled cycle. Back-to-back operands never interfere.
- o_p is computed and updated for i_valid=0 inputs too; the value is don't-care. o_valid is the only qualifier, and a bench must not check o_p when o_valid=0.
- Zero operands give exactly 0. A negative-zero result is impossible after the two's-complement negate.
- Odd IAW: the top 2-bit slice is {1'b0, msb of ma}. Results are identical to the even case.
- Unsigned mode: the result equals the exact OW-bit product, e.g. (2^IAW-1)*(2^IBW-1) for full-scale operands.
- No combinational path from any input to any output.

Test Plan:
1. IAW=IBW=8, signed, i_ce=1. Drive i_a=-128, i_b=-128, i_valid=1 for one cycle -> o_valid=1 exactly 6 cycles later with o_p=16384 (0x4000); o_valid=0 on every other cycle.
2. Signed 8x8, back-to-back over consecutive cycles: (127,-128), (-1,-1), (0,-77), (-5,3) -> four consecutive o_valid pulses carrying -16256, 1, 0, -15 in order.
3. OPT_SIGNED=0, 8x8: (255,255) then (1,200) -> 65025 then 200, latency 6.
4. IAW=7, IBW=5, signed (K=4, LAT=6): (-64,-16) -> 1024; (63,15) -> 945.
5. Stall: launch (12,-3) then hold i_ce=0 for 3 cycles after 2 enabled edges -> o_valid/o_p frozen during the stall; -36 emerges after 4 more enabled edges.
6. Reset mid-flight: launch 3 valid pairs, then assert i_reset_n=0 asynchronously between edges -> o_valid=0 and o_p=0 immediately. No o_valid pulse after release until new operands arrive, which then produce correct products at LAT.
